// File: rtl/mundo_ctrl.sv
// World-progression controller: qualifies the current world's Set flag, celebrates, advances.
// Optional skip input enabled by defining MUNDO_CTRL_SKIP_EN.
module mundo_ctrl #(
  parameter int NUM_WORLDS  = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int SHOW_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_WORLDS-1:0] set_vec,
`ifdef MUNDO_CTRL_SKIP_EN
  input  logic                  skip,
`endif
  output logic [2:0]            world,
  output logic                  world_done,
  output logic                  busy,
  output logic                  all_done,
  output logic [6:0]            seg
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SHOW_M1 = SW'(SHOW_CYCLES - 1);
  localparam logic [2:0]    LAST_W  = 3'(NUM_WORLDS - 1);
  localparam logic [6:0]    SEG_F   = 7'h71;

  typedef enum logic [1:0] {PLAY, SHOW, DONE} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [2:0]    world_q, world_d;
  logic          world_done_q, world_done_d;
  logic          busy_q, busy_d;
  logic          all_done_q, all_done_d;
  logic [6:0]    seg_q, seg_d;
  logic          sel, skip_w, qual, show_last, world_last;

  // Digit shown for world index w is w+1.
  function automatic logic [6:0] seg_of(input logic [2:0] w);
    case (w)
      3'd0:    seg_of = 7'h06;
      3'd1:    seg_of = 7'h5B;
      3'd2:    seg_of = 7'h4F;
      3'd3:    seg_of = 7'h66;
      3'd4:    seg_of = 7'h6D;
      3'd5:    seg_of = 7'h7D;
      3'd6:    seg_of = 7'h07;
      default: seg_of = 7'h7F;
    endcase
  endfunction

`ifdef MUNDO_CTRL_SKIP_EN
  assign skip_w = skip;
`else
  assign skip_w = 1'b0;
`endif

  always_comb begin
    sel = 1'b0;
    for (int i = 0; i < NUM_WORLDS; i++)
      if (world_q == 3'(i)) sel = set_vec[i];
  end

  assign qual       = skip_w | (sel & (hold_cnt_q == HOLD_M1));
  assign show_last  = (show_cnt_q == SHOW_M1);
  assign world_last = (world_q == LAST_W);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= PLAY;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY:    if (qual) state_d = SHOW;
      SHOW:    if (show_last) state_d = world_last ? DONE : PLAY;
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    show_cnt_d   = show_cnt_q;
    world_d      = world_q;
    world_done_d = 1'b0;
    busy_d       = busy_q;
    all_done_d   = all_done_q;
    seg_d        = seg_q;
    case (state_q)
      PLAY: begin
        if (qual) begin
          hold_cnt_d   = '0;
          show_cnt_d   = '0;
          world_done_d = 1'b1;
          busy_d       = 1'b1;
        end else if (sel) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          hold_cnt_d = '0;
        end
      end
      SHOW: begin
        if (show_last) begin
          show_cnt_d = '0;
          busy_d     = 1'b0;
          if (world_last) begin
            all_done_d = 1'b1;
            seg_d      = SEG_F;
          end else begin
            world_d = world_q + 3'd1;
            seg_d   = seg_of(world_q + 3'd1);
          end
        end else begin
          show_cnt_d = show_cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d     = 1'b0;
        all_done_d = 1'b1;
        seg_d      = SEG_F;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      show_cnt_q   <= '0;
      world_q      <= '0;
      world_done_q <= 1'b0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      seg_q        <= 7'h06;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      show_cnt_q   <= show_cnt_d;
      world_q      <= world_d;
      world_done_q <= world_done_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      seg_q        <= seg_d;
    end

  assign world      = world_q;
  assign world_done = world_done_q;
  assign busy       = busy_q;
  assign all_done   = all_done_q;
  assign seg        = seg_q;

endmodule
